// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the in-order core.
// Holds the scoreboard entry, the stage indices and the forwarding-width helper.
package cpu_pipe_pkg;

    // Widest register address any core build uses; narrower builds zero-extend.
    localparam int RA_W = 8;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            wr;
        logic            is_load;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } sb_entry_t;

    function automatic int fwd_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one scoreboard entry.
// Register x0 never produces a match.
module hazard_match
    import cpu_pipe_pkg::*;
(
    input  logic            i_valid,
    input  sb_entry_t       i_entry,
    input  logic [RA_W-1:0] i_src,
    input  logic            i_used,
    output logic            o_match
);

    assign o_match = i_valid & i_entry.wr & i_used &
                     (i_entry.rd == i_src) & (i_src != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage pipeline control: valid bits, scoreboard, stalls, flushes
// and EX operand forwarding selects.
module pipeline_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STAGE = 4,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16,
    parameter int FWD_W      = fwd_w(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rd_wr,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  pc_hold,
    output logic [NUM_STAGES-2:0] stage_adv,
    output logic [NUM_STAGES-2:0] stage_valid,
    output logic [FWD_W-1:0]      fwd_sel_a,
    output logic [FWD_W-1:0]      fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int NR = NUM_STAGES - 1;

    logic [NR-1:0]    r_valid;
    sb_entry_t        r_sb [1:NR-1];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [RA_W-1:0]  w_rs1;
    logic [RA_W-1:0]  w_rs2;
    logic [NR-1:1]    w_id_m1;
    logic [NR-1:1]    w_id_m2;
    logic [NR-1:1]    w_hz;
    logic [NR-1:2]    w_fa;
    logic [NR-1:2]    w_fb;
    logic             w_stall;
    logic             w_load1;
    sb_entry_t        w_new;
    logic [FWD_W-1:0] w_sel_a;
    logic [FWD_W-1:0] w_sel_b;
    logic [NR-1:1]    w_unused_bits;

    assign w_rs1 = RA_W'(id_rs1_addr);
    assign w_rs2 = RA_W'(id_rs2_addr);

    // Register k holds the instruction currently in stage k+1.
    for (genvar k = 1; k < NR; k++) begin : g_id
        hazard_match u_m1 (
            .i_valid (r_valid[k]),
            .i_entry (r_sb[k]),
            .i_src   (w_rs1),
            .i_used  (id_rs1_used),
            .o_match (w_id_m1[k])
        );
        hazard_match u_m2 (
            .i_valid (r_valid[k]),
            .i_entry (r_sb[k]),
            .i_src   (w_rs2),
            .i_used  (id_rs2_used),
            .o_match (w_id_m2[k])
        );
        if (FWD_EN != 0) begin : g_ld
            localparam bit LU = (k + 2) < LOAD_STAGE;
            assign w_hz[k] = (w_id_m1[k] | w_id_m2[k]) &
                             r_sb[k].is_load & LU;
        end else begin : g_any
            assign w_hz[k] = w_id_m1[k] | w_id_m2[k];
        end
        assign w_unused_bits[k] = ^{r_sb[k].rs1, r_sb[k].rs2,
                                    r_sb[k].is_load};
    end

    for (genvar k = 2; k < NR; k++) begin : g_fwd
        hazard_match u_fa (
            .i_valid (r_valid[k]),
            .i_entry (r_sb[k]),
            .i_src   (r_sb[STG_ID].rs1),
            .i_used  (1'b1),
            .o_match (w_fa[k])
        );
        hazard_match u_fb (
            .i_valid (r_valid[k]),
            .i_entry (r_sb[k]),
            .i_src   (r_sb[STG_ID].rs2),
            .i_used  (1'b1),
            .o_match (w_fb[k])
        );
    end

    // A taken branch discards the ID instruction, so it never stalls.
    assign w_stall = r_valid[STG_IF] & (|w_hz) & ~ex_branch_taken;
    assign w_load1 = r_valid[STG_IF] & ~w_stall & ~ex_branch_taken;

    always_comb begin
        w_new = '0;
        if (w_load1) begin
            w_new.rd      = RA_W'(id_rd_addr);
            w_new.wr      = id_rd_wr;
            w_new.is_load = id_is_load;
            w_new.rs1     = id_rs1_used ? w_rs1 : '0;
            w_new.rs2     = id_rs2_used ? w_rs2 : '0;
        end
    end

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = NR - 1; k >= 2; k--) begin
            if (w_fa[k]) w_sel_a = FWD_W'(k + 1);
            if (w_fb[k]) w_sel_b = FWD_W'(k + 1);
        end
        if (FWD_EN == 0) begin
            w_sel_a = '0;
            w_sel_b = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            for (int k = 1; k < NR; k++) r_sb[k] <= '0;
        end else begin
            if (ex_branch_taken)
                r_valid[STG_IF] <= 1'b0;
            else if (!w_stall)
                r_valid[STG_IF] <= fetch_valid;
            r_valid[STG_ID] <= w_load1;
            r_sb[STG_ID]    <= w_new;
            for (int k = 2; k < NR; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_sb[k]    <= r_sb[k-1];
            end
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (ex_branch_taken && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign pc_hold     = w_stall;
    assign stage_adv   = {{(NR-1){1'b1}}, ~w_stall};
    assign stage_valid = r_valid;
    assign fwd_sel_a   = w_sel_a;
    assign fwd_sel_b   = w_sel_b;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: default build (A) and a 7-stage,
// no-forwarding, 4-bit-counter build (B) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_valid = 1'b0;
    logic [4:0] id_rs1_addr = '0;
    logic [4:0] id_rs2_addr = '0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic [4:0] id_rd_addr = '0;
    logic       id_rd_wr = 1'b0;
    logic       id_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0;

    logic        a_hold;
    logic [3:0]  a_adv, a_vld;
    logic [2:0]  a_fa, a_fb;
    logic [15:0] a_sc, a_fc;
    logic        b_hold;
    logic [5:0]  b_adv, b_vld;
    logic [2:0]  b_fa, b_fb;
    logic [3:0]  b_sc, b_fc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut_a (
        .clk (clk), .rst (rst), .fetch_valid (fetch_valid),
        .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
        .id_rd_addr (id_rd_addr), .id_rd_wr (id_rd_wr),
        .id_is_load (id_is_load), .ex_branch_taken (ex_branch_taken),
        .pc_hold (a_hold), .stage_adv (a_adv), .stage_valid (a_vld),
        .fwd_sel_a (a_fa), .fwd_sel_b (a_fb),
        .stall_cnt (a_sc), .flush_cnt (a_fc)
    );

    pipeline_hazard_ctrl #(
        .NUM_STAGES (7), .LOAD_STAGE (6), .FWD_EN (0), .CNT_W (4)
    ) u_dut_b (
        .clk (clk), .rst (rst), .fetch_valid (fetch_valid),
        .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
        .id_rd_addr (id_rd_addr), .id_rd_wr (id_rd_wr),
        .id_is_load (id_is_load), .ex_branch_taken (ex_branch_taken),
        .pc_hold (b_hold), .stage_adv (b_adv), .stage_valid (b_vld),
        .fwd_sel_a (b_fa), .fwd_sel_b (b_fb),
        .stall_cnt (b_sc), .flush_cnt (b_fc)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: one instruction record per occupied stage.
    // Index p = pipeline register p, i.e. the instruction in stage p+1.
    function automatic int nst(input int i); return i == 0 ? 5 : 7; endfunction
    function automatic int lst(input int i); return i == 0 ? 4 : 6; endfunction
    function automatic bit fen(input int i); return i == 0; endfunction
    function automatic int cmax(input int i); return i == 0 ? 65535 : 15; endfunction

    bit mv  [2][8];
    bit mwr [2][8];
    bit mld [2][8];
    int mrd [2][8];
    int ms1 [2][8];
    int ms2 [2][8];
    int msc [2];
    int mfc [2];
    bit mst [2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 8; p++) begin
                mv[i][p] = 0; mwr[i][p] = 0; mld[i][p] = 0;
                mrd[i][p] = 0; ms1[i][p] = 0; ms2[i][p] = 0;
            end
            msc[i] = 0; mfc[i] = 0; mst[i] = 0;
        end
    endtask

    function automatic bit wr_at(input int i, input int s, input int r);
        return mv[i][s-1] && mwr[i][s-1] && r != 0 && mrd[i][s-1] == r;
    endfunction

    task automatic m_eval(input int i, output bit stall,
                          output int fa, output int fb);
        bit hz = 0;
        bit m;
        for (int s = 2; s < nst(i); s++) begin
            m = (id_rs1_used && wr_at(i, s, int'(id_rs1_addr))) ||
                (id_rs2_used && wr_at(i, s, int'(id_rs2_addr)));
            // With forwarding only a load whose data is not yet ready hurts.
            if (m && (!fen(i) || (mld[i][s-1] && s + 1 < lst(i)))) hz = 1;
        end
        stall = mv[i][0] && hz && !ex_branch_taken;
        fa = 0;
        fb = 0;
        if (fen(i)) begin
            for (int s = nst(i) - 1; s >= 3; s--) begin
                if (wr_at(i, s, ms1[i][1])) fa = s;
                if (wr_at(i, s, ms2[i][1])) fb = s;
            end
        end
    endtask

    task automatic m_update(input int i);
        bit ld;
        if (rst) begin
            for (int p = 0; p < 8; p++) begin
                mv[i][p] = 0; mwr[i][p] = 0; mld[i][p] = 0;
                mrd[i][p] = 0; ms1[i][p] = 0; ms2[i][p] = 0;
            end
            msc[i] = 0; mfc[i] = 0;
            return;
        end
        for (int p = nst(i) - 2; p >= 2; p--) begin
            mv[i][p] = mv[i][p-1]; mwr[i][p] = mwr[i][p-1];
            mld[i][p] = mld[i][p-1]; mrd[i][p] = mrd[i][p-1];
            ms1[i][p] = ms1[i][p-1]; ms2[i][p] = ms2[i][p-1];
        end
        ld = mv[i][0] && !mst[i] && !ex_branch_taken;
        mv[i][1]  = ld;
        mwr[i][1] = ld && id_rd_wr;
        mld[i][1] = ld && id_is_load;
        mrd[i][1] = ld ? int'(id_rd_addr) : 0;
        ms1[i][1] = (ld && id_rs1_used) ? int'(id_rs1_addr) : 0;
        ms2[i][1] = (ld && id_rs2_used) ? int'(id_rs2_addr) : 0;
        if (ex_branch_taken) mv[i][0] = 0;
        else if (!mst[i]) mv[i][0] = fetch_valid;
        if (mst[i] && msc[i] < cmax(i)) msc[i]++;
        if (ex_branch_taken && mfc[i] < cmax(i)) mfc[i]++;
    endtask

    task automatic cyc();
        int efa, efb, ev, ea;
        logic [31:0] h, ad, vl, fa, fb, sc, fc;
        string p;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_eval(i, mst[i], efa, efb);
            ev = 0;
            for (int k = 0; k < nst(i) - 1; k++)
                if (mv[i][k]) ev |= (1 << k);
            ea = ((1 << (nst(i) - 1)) - 1) & ~int'(mst[i]);
            if (i == 0) begin
                p = "A."; h = 32'(a_hold); ad = 32'(a_adv); vl = 32'(a_vld);
                fa = 32'(a_fa); fb = 32'(a_fb); sc = 32'(a_sc); fc = 32'(a_fc);
            end else begin
                p = "B."; h = 32'(b_hold); ad = 32'(b_adv); vl = 32'(b_vld);
                fa = 32'(b_fa); fb = 32'(b_fb); sc = 32'(b_sc); fc = 32'(b_fc);
            end
            check({p, "pc_hold"}, h, 32'(mst[i]));
            check({p, "stage_adv"}, ad, ea);
            check({p, "stage_valid"}, vl, ev);
            check({p, "fwd_sel_a"}, fa, efa);
            check({p, "fwd_sel_b"}, fb, efb);
            check({p, "stall_cnt"}, sc, msc[i]);
            check({p, "flush_cnt"}, fc, mfc[i]);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
    endtask

    task automatic set_id(input bit fv, input int rd, input bit wr,
                          input bit ld, input int r1, input bit u1,
                          input int r2, input bit u2, input bit br);
        fetch_valid = fv;
        id_rd_addr = 5'(rd); id_rd_wr = wr; id_is_load = ld;
        id_rs1_addr = 5'(r1); id_rs1_used = u1;
        id_rs2_addr = 5'(r2); id_rs2_used = u2;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset takes effect asynchronously, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.A.valid", 32'(a_vld), 0);
        check("rst.A.hold", 32'(a_hold), 0);
        check("rst.A.adv", 32'(a_adv), 32'hf);
        check("rst.A.cnt", 32'({a_sc, a_fc}), 0);
        check("rst.B.valid", 32'(b_vld), 0);
        check("rst.B.hold", 32'(b_hold), 0);
        check("rst.B.cnt", 32'({b_sc, b_fc}), 0);
        m_reset();
        cyc();
        adv();
        rst = 1'b0;
    endtask

    task automatic pair_b(output int n);
        bit h;
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc(); adv();
        set_id(1, 6, 1, 0, 5, 1, 1, 1, 0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            h = b_hold;
            if (h) n++;
            adv();
            if (!h) break;
        end
    endtask

    initial begin
        int n;
        m_reset();
        do_reset();

        // load-use: lw x5 ; add x6,x5,x1
        nop(); cyc(); adv();
        set_id(1, 5, 1, 1, 2, 1, 0, 0, 0); cyc(); adv();
        set_id(1, 6, 1, 0, 5, 1, 1, 1, 0); cyc();
        check("lu.hold", 32'(a_hold), 1);
        check("lu.adv0", 32'(a_adv[0]), 0);
        adv();
        cyc();
        check("lu.hold_end", 32'(a_hold), 0);
        check("lu.bubble", 32'(a_vld[1]), 0);
        check("lu.load_in_mem", 32'(a_vld[2]), 1);
        adv();
        nop(); cyc();
        check("lu.fwd_a", 32'(a_fa), 4);
        check("lu.fwd_b", 32'(a_fb), 0);
        check("lu.stall_cnt", 32'(a_sc), 1);
        adv();

        // ALU chain: add x5 ; add x7,x5,x5 ; add x8,x5,x0
        do_reset();
        nop(); cyc(); adv();
        set_id(1, 5, 1, 0, 1, 1, 2, 1, 0); cyc(); adv();
        set_id(1, 7, 1, 0, 5, 1, 5, 1, 0); cyc();
        check("alu.hold", 32'(a_hold), 0);
        adv();
        set_id(1, 8, 1, 0, 5, 1, 0, 1, 0); cyc();
        check("alu.fwd_a", 32'(a_fa), 3);
        check("alu.fwd_b", 32'(a_fb), 3);
        adv();
        nop(); cyc();
        check("alu2.fwd_a", 32'(a_fa), 4);
        check("alu2.fwd_b", 32'(a_fb), 0);
        adv();

        // x0 destination, written by a load, never matches
        do_reset();
        nop(); cyc(); adv();
        set_id(1, 0, 1, 1, 0, 0, 0, 0, 0); cyc(); adv();
        set_id(1, 1, 1, 0, 0, 1, 0, 1, 0); cyc();
        check("x0.hold", 32'(a_hold), 0);
        adv();
        nop(); cyc();
        check("x0.fwd", 32'({a_fa, a_fb}), 0);
        adv();

        // taken branch in the same cycle as a load-use hazard
        do_reset();
        nop(); cyc(); adv();
        set_id(1, 5, 1, 1, 0, 0, 0, 0, 0); cyc(); adv();
        set_id(1, 6, 1, 0, 5, 1, 1, 1, 1); cyc();
        check("br.hold", 32'(a_hold), 0);
        check("br.adv", 32'(a_adv), 32'hf);
        adv();
        nop(); cyc();
        check("br.valid", 32'(a_vld[1:0]), 0);
        check("br.flush_cnt", 32'(a_fc), 1);
        check("br.stall_cnt", 32'(a_sc), 0);
        adv();

        // B: dependent pairs stall while the producer sits in stages 2..6
        do_reset();
        nop(); cyc(); adv();
        for (int r = 0; r < 4; r++) begin
            pair_b(n);
            check("b.pair_stalls", n, 5);
        end
        check("b.stall_sat", 32'(b_sc), 15);
        check("a.no_alu_stall", 32'(a_sc), 0);
        for (int r = 0; r < 20; r++) begin
            set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
            cyc(); adv();
        end
        check("b.flush_sat", 32'(b_fc), 15);
        check("a.flush_cnt", 32'(a_fc), 20);

        // random traffic with a mid-run reset
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 9) == 0);
            cyc();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
